// File: rtl/virq_pkg.sv
// Shared types and constants for the vectored-interrupt arbiter.
// prio4 is the fixed-priority encoder: the lowest set bit wins.
package virq_pkg;

    localparam int NSRC = 4;

    localparam logic [8:0] VEC_KBD60  = 9'o060;
    localparam logic [8:0] VEC_KBD274 = 9'o274;
    localparam logic [8:0] VEC_TIMER  = 9'o100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Returns {found, idx}; found=0 when nothing is eligible.
    function automatic logic [2:0] prio4(input logic [NSRC-1:0] eligible);
        logic [2:0] res;
        res = 3'b000;
        if (eligible[0])      res = 3'b100;
        else if (eligible[1]) res = 3'b101;
        else if (eligible[2]) res = 3'b110;
        else if (eligible[3]) res = 3'b111;
        return res;
    endfunction

endpackage

// File: rtl/virq_arbiter.sv
// Fixed-priority sharing of the CPU vectored-interrupt input among four
// peripherals, routing the CPU iack back as a per-source ack level.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing presented; arbitrate eligible requests
// PEND  | cpu_virq high with the latched vector, waiting for cpu_iack
// ACK   | virq_ack[idx] high until the source drops its request or times out
// GAP   | one quiet cycle so the ack falling edge precedes any new grant
module virq_arbiter
    import virq_pkg::*;
#(
    parameter logic [8:0] VEC0    = VEC_KBD60,
    parameter logic [8:0] VEC1    = VEC_KBD274,
    parameter logic [8:0] VEC2    = VEC_TIMER,
    parameter logic [8:0] VEC3    = 9'o000,
    parameter int         TIMEOUT = 255
) (
    input  logic            clk_bus,
    input  logic            bus_reset,
    input  logic [NSRC-1:0] virq_req,
    input  logic [NSRC-1:0] virq_mask,
    output logic [NSRC-1:0] virq_ack,
    output logic            cpu_virq,
    output logic [8:0]      cpu_vector,
    input  logic            cpu_iack,
    output logic            ack_timeout,
    output logic            busy
);

    localparam logic [NSRC-1:0] ENABLED = {VEC3 != 9'd0, VEC2 != 9'd0,
                                           VEC1 != 9'd0, VEC0 != 9'd0};
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      idx;
    logic [8:2]      vec_q;
    logic [7:0]      cnt;
    logic            to_q;

    logic [NSRC-1:0] eligible;
    logic [2:0]      sel;
    logic [8:2]      sel_vec;
    logic            req_held;
    logic            expire;

    assign eligible = virq_req & ~virq_mask & ENABLED;
    assign sel      = prio4(eligible);
    assign req_held = virq_req[idx];
    assign expire   = req_held && (cnt == TO_LAST);

    // Vector bits [1:0] are never stored, so the presented vector is always word aligned.
    always_comb begin
        sel_vec = VEC0[8:2];
        case (sel[1:0])
            2'd0:    sel_vec = VEC0[8:2];
            2'd1:    sel_vec = VEC1[8:2];
            2'd2:    sel_vec = VEC2[8:2];
            default: sel_vec = VEC3[8:2];
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sel[2]) state_nxt = PEND;
            end
            PEND: begin
                if (cpu_iack)       state_nxt = ACK;
                else if (!req_held) state_nxt = IDLE;
            end
            ACK: begin
                if (!req_held || expire) state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping: winner index/vector, ack-duration counter, timeout flag.
    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            idx   <= 2'd0;
            vec_q <= '0;
            cnt   <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            to_q <= (state == ACK) && expire;
            if (state == IDLE && sel[2]) begin
                idx   <= sel[1:0];
                vec_q <= sel_vec;
            end
            if (state == PEND && cpu_iack) begin
                cnt <= 8'd0;
            end else if (state == ACK && cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_comb begin
        cpu_virq    = 1'b0;
        cpu_vector  = 9'd0;
        virq_ack    = '0;
        busy        = (state != IDLE);
        ack_timeout = to_q;
        case (state)
            PEND: begin
                cpu_virq   = 1'b1;
                cpu_vector = {vec_q, 2'b00};
            end
            ACK: begin
                virq_ack[idx] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/virq_arbiter.md
Name: virq_arbiter

Overview:
- Shares the single CPU vectored-interrupt input between up to four peripheral requesters: keyboard 060, keyboard 274, timer, and a spare.
- Performs fixed-priority selection and presents one vector at a time to the CPU core.
- Routes the CPU's interrupt acknowledge back to the winning source as a per-source ack level. Keyboard-style blocks edge-detect this level to clear their request.
- Sits between peripheral virq_req/virq_ack pairs and the CPU core's virq/vector/iack port, in the clk_bus domain.

Parameters:
- VEC0, 9'o060: vector for source 0 (highest priority).
- VEC1, 9'o274: vector for source 1.
- VEC2, 9'o100: vector for source 2.
- VEC3, 9'o000: vector for source 3 (lowest priority). 0 means the source is disabled at elaboration and its request is ignored.
- TIMEOUT, 255: maximum number of cycles ack stays high waiting for the request to drop. Valid range 1..255.

Ports:
- clk_bus  in  1  system bus clock; all logic on its rising edge.
- bus_reset  in  1  synchronous, active-high reset.
- virq_req  in  4  per-source request levels; bit 0 has highest priority.
- virq_mask  in  4  1 = source masked; it is ignored for new arbitration.
- virq_ack  out  4  per-source acknowledge level, at most one bit high.
- cpu_virq  out  1  interrupt request to the CPU.
- cpu_vector  out  9  vector address of the presented source; bits [1:0] always 0.
- cpu_iack  in  1  one-cycle pulse: CPU has taken the vector.
- ack_timeout  out  1  one-cycle pulse: a source failed to drop its request within TIMEOUT cycles.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (bus_reset high at a clock edge): state=IDLE, timeout counter=0, selected index=0. All outputs 0 from that edge. This holds in any state, including mid-ACK. There is no ack pulse on reset and no pending grant is remembered.
- eligible = virq_req & ~virq_mask & enabled, where enabled[i] = (VECi != 0).
- Priority: fixed, lowest index wins. No rotation, no preemption once PEND is entered.
- IDLE:
  - If eligible != 0, latch idx = highest-priority eligible source and latch vec = VECidx; go to PEND.
  - cpu_virq rises on the cycle after the request is seen, so request-to-cpu_virq latency is 1 cycle.
- PEND:
  - cpu_virq=1 and cpu_vector=vec, both stable for the whole state.
  - cpu_iack=1 → go to ACK. virq_ack[idx] goes to 1 and cpu_virq goes to 0 on the next edge. Counter cleared.
  - Otherwise, if virq_req[idx]=0 (withdrawn, e.g. a keyboard data read clears it) → go to IDLE with no ack; cpu_virq drops next edge.
  - If withdraw and cpu_iack occur in the same cycle, iack wins and the block goes to ACK.
  - virq_mask changes while in PEND are ignored; the mask only gates new selection.
- ACK:
  - virq_ack[idx]=1; counter increments every cycle.
  - If virq_req[idx]=0 → go to GAP.
  - Else if counter reaches TIMEOUT-1 → go to GAP and pulse ack_timeout for one cycle.
  - In both cases virq_ack drops on the edge entering GAP.
  - Any cpu_iack arriving in ACK or GAP is ignored.
- GAP: one cycle with all outputs idle, so the ack falling edge is always seen before a new grant; then go to IDLE.
- Minimum grant-to-grant spacing: IDLE→PEND→ACK→GAP→IDLE→PEND, i.e. 5 cycles when iack is immediate and the source drops its request after one ack cycle.
- cpu_vector is 0 whenever cpu_virq=0.
- Counter: 8-bit, saturating; it never wraps.
- A masked source keeps its request pending; it is arbitrated as soon as its mask bit clears and the block is in IDLE.

Decomposition:
- Shared package virq_pkg:
  - state enum {IDLE, PEND, ACK, GAP}, 2 bits.
  - constants VEC_KBD60=9'o060, VEC_KBD274=9'o274, VEC_TIMER=9'o100.
  - NSRC=4.
- No sub-module. The priority encoder is a function in the package, prio4(eligible) returning {found, idx[1:0]}.

Test Plan:
1. Reset in PEND with req=4'b0010: assert bus_reset for 1 cycle → next cycle cpu_virq=0, virq_ack=0, busy=0. Then release with req still 4'b0010 → cpu_virq=1 with vector 9'o274 one cycle after reset release.
2. Simultaneous req=4'b0011, iack 2 cycles after cpu_virq: vector 9'o060 presented, then virq_ack=4'b0001. After source 0 drops, source 1 is granted with vector 9'o274 exactly 2 cycles after its ack falls.
3. Withdraw: req=4'b0001, cpu_virq seen, req drops before iack → cpu_virq=0 next cycle, virq_ack never asserts, state IDLE.
4. Same-cycle withdraw and iack: virq_ack[0] high for exactly 1 cycle, then 1 GAP cycle, no ack_timeout.
5. Timeout with TIMEOUT=8: source 2 never drops req after iack → virq_ack[2] high for 8 cycles, ack_timeout single pulse, then re-grant of vector 9'o100 after GAP (req still high).
6. Mask: req=4'b0001 with mask=4'b0001 → no cpu_virq for 20 cycles. Clear mask → cpu_virq 1 cycle later with vector 9'o060. Mask set while in PEND → grant still completes.
